branch_sequencer: RTL and testbench

Sequences shared use of the condition-evaluation unit (the combinational compare block with Op_code/Addr_1/Addr_2 in and a 16-bit 0/1 result out) between two branch requesters. It arbitrates round-robin, registers the operands driven to the unit, and captures its result. It returns a taken/not-taken decision with the branch target over a valid/ready response channel, and keeps saturating branch statistics. It sits between instruction decode (two issue slots) and the PC update logic.

---
 rtl/branch_sequencer_if.sv | 59 +++++
 rtl/branch_sequencer.sv | 118 +++++++++++
 tb/tb_branch_sequencer.sv | 343 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/branch_sequencer_if.sv
// branch_sequencer_if: bundle of every non-clock/reset signal of branch_sequencer.
//   req0_* / req1_* : two branch requesters (valid/ready, cond code, operands, target)
//   cond_*          : operands to and result from the condition-evaluation unit
//   resp_*          : taken/not-taken decision channel (valid/ready)
//   stat_clr, total_count, taken_count : statistics
// master = surrounding logic (decode, condition unit, PC update); slave = sequencer.
interface branch_sequencer_if #(
  parameter int PC_WIDTH   = 16,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
);
  logic                  req0_valid;
  logic                  req0_ready;
  logic [7:0]            req0_cond;
  logic [DATA_WIDTH-1:0] req0_a;
  logic [DATA_WIDTH-1:0] req0_b;
  logic [PC_WIDTH-1:0]   req0_target;

  logic                  req1_valid;
  logic                  req1_ready;
  logic [7:0]            req1_cond;
  logic [DATA_WIDTH-1:0] req1_a;
  logic [DATA_WIDTH-1:0] req1_b;
  logic [PC_WIDTH-1:0]   req1_target;

  logic [31:0]           cond_op;
  logic [DATA_WIDTH-1:0] cond_a;
  logic [DATA_WIDTH-1:0] cond_b;
  logic [15:0]           cond_result;

  logic                  resp_valid;
  logic                  resp_ready;
  logic                  resp_taken;
  logic [PC_WIDTH-1:0]   resp_target;
  logic                  resp_id;
  logic                  resp_illegal;

  logic                  stat_clr;
  logic [CNT_WIDTH-1:0]  total_count;
  logic [CNT_WIDTH-1:0]  taken_count;

  modport master (
    output req0_valid, req0_cond, req0_a, req0_b, req0_target,
    output req1_valid, req1_cond, req1_a, req1_b, req1_target,
    output cond_result, resp_ready, stat_clr,
    input  req0_ready, req1_ready, cond_op, cond_a, cond_b,
    input  resp_valid, resp_taken, resp_target, resp_id, resp_illegal,
    input  total_count, taken_count
  );

  modport slave (
    input  req0_valid, req0_cond, req0_a, req0_b, req0_target,
    input  req1_valid, req1_cond, req1_a, req1_b, req1_target,
    input  cond_result, resp_ready, stat_clr,
    output req0_ready, req1_ready, cond_op, cond_a, cond_b,
    output resp_valid, resp_taken, resp_target, resp_id, resp_illegal,
    output total_count, taken_count
  );
endinterface

// File: rtl/branch_sequencer.sv
// branch_sequencer: shares the condition-evaluation unit between two branch
// requesters. Round-robin grant in IDLE, registered operands to the unit in
// ISSUE, decision held on a valid/ready response channel in RESP. Keeps
// saturating counts of completed and taken branches.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset
//   bus  - branch_sequencer_if.slave (requests, condition unit, response, stats)
module branch_sequencer #(
  parameter int PC_WIDTH   = 16,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input logic               clk,
  input logic               rst,
  branch_sequencer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t                state, next_state;
  logic                  last_grant;
  logic                  grant0, grant1, grant_any, handshake;
  logic [7:0]            sel_cond;
  logic [31:0]           op_q;
  logic [DATA_WIDTH-1:0] a_q, b_q;
  logic [PC_WIDTH-1:0]   target_q;
  logic                  id_q, illegal_q, taken_q;
  logic [CNT_WIDTH-1:0]  total_q, taken_cnt_q;
  logic                  unused_result_bits;

  // Only bit 0 of the unit's result carries the decision.
  assign unused_result_bits = ^bus.cond_result[15:1];

  always_comb begin
    grant0     = 1'b0;
    grant1     = 1'b0;
    next_state = state;
    unique case (state)
      IDLE: begin
        if (bus.req0_valid && bus.req1_valid) begin
          // Tie: favour whoever was not granted last time.
          grant0 = last_grant;
          grant1 = ~last_grant;
        end else begin
          grant0 = bus.req0_valid;
          grant1 = bus.req1_valid;
        end
        if (grant0 || grant1) next_state = ISSUE;
      end
      ISSUE:   next_state = RESP;
      RESP:    if (bus.resp_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign grant_any = grant0 | grant1;
  assign handshake = (state == RESP) && bus.resp_ready;
  assign sel_cond  = grant1 ? bus.req1_cond : bus.req0_cond;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= 1'b1;
      id_q       <= 1'b0;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      target_q   <= '0;
      illegal_q  <= 1'b0;
      taken_q    <= 1'b0;
    end else begin
      if (grant_any) begin
        last_grant <= grant1;
        id_q       <= grant1;
        op_q       <= {24'd0, sel_cond};
        a_q        <= grant1 ? bus.req1_a      : bus.req0_a;
        b_q        <= grant1 ? bus.req1_b      : bus.req0_b;
        target_q   <= grant1 ? bus.req1_target : bus.req0_target;
        illegal_q  <= (sel_cond > 8'd9);
      end
      // Illegal codes never report taken, whatever the unit returns.
      if (state == ISSUE) taken_q <= bus.cond_result[0] & ~illegal_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      total_q     <= '0;
      taken_cnt_q <= '0;
    end else if (bus.stat_clr) begin
      total_q     <= '0;
      taken_cnt_q <= '0;
    end else if (handshake) begin
      if (total_q != '1)                taken_cnt_q <= taken_cnt_q;
      if (total_q != '1)                total_q     <= total_q + 1'b1;
      if (taken_q && taken_cnt_q != '1) taken_cnt_q <= taken_cnt_q + 1'b1;
    end
  end

  assign bus.req0_ready   = grant0;
  assign bus.req1_ready   = grant1;
  assign bus.cond_op      = op_q;
  assign bus.cond_a       = a_q;
  assign bus.cond_b       = b_q;
  assign bus.resp_valid   = (state == RESP);
  assign bus.resp_taken   = taken_q;
  assign bus.resp_target  = target_q;
  assign bus.resp_id      = id_q;
  assign bus.resp_illegal = illegal_q;
  assign bus.total_count  = total_q;
  assign bus.taken_count  = taken_cnt_q;

endmodule

// File: tb/tb_branch_sequencer.sv
// Self-checking bench for branch_sequencer. Counters are built 4 bits wide so
// saturation is reachable in a short run.
module tb_branch_sequencer;
  localparam int PW   = 16;
  localparam int DW   = 32;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  branch_sequencer_if #(.PC_WIDTH(PW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();

  branch_sequencer #(.PC_WIDTH(PW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int failures = 0;

  // Reference semantics of the 10 condition codes.
  function automatic bit eval_cond(input logic [31:0] code, input logic [31:0] a, input logic [31:0] b);
    case (code)
      0: return a == b;
      1: return a != b;
      2: return a < b;
      3: return a <= b;
      4: return a > b;
      5: return a >= b;
      6: return $signed(a) < $signed(b);
      7: return $signed(a) <= $signed(b);
      8: return $signed(a) > $signed(b);
      9: return $signed(a) >= $signed(b);
      default: return 1'b0;
    endcase
  endfunction

  // Condition unit stand-in; "garbage" makes it return all-ones for illegal codes.
  bit garbage = 1'b0;
  always_comb begin
    bus.cond_result = '0;
    if (bus.cond_op > 32'd9) bus.cond_result = garbage ? 16'hFFFF : 16'h0000;
    else                     bus.cond_result[0] = eval_cond(bus.cond_op, bus.cond_a, bus.cond_b);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Drive values applied on the next step.
  bit          d_v0, d_v1, d_rr, d_clr;
  logic [7:0]  d_c0, d_c1;
  logic [31:0] d_a0, d_b0, d_a1, d_b1;
  logic [15:0] d_t0, d_t1;

  // Transaction-level reference model.
  typedef struct {
    bit          taken;
    bit          illegal;
    bit          id;
    logic [15:0] target;
    logic [7:0]  cond;
    logic [31:0] a;
    logic [31:0] b;
  } exp_t;
  exp_t m_exp;
  bit   m_busy, m_last;
  int   m_age, m_tot, m_tak;

  task automatic apply();
    bus.req0_valid = d_v0;  bus.req0_cond = d_c0;  bus.req0_a = d_a0;
    bus.req0_b = d_b0;      bus.req0_target = d_t0;
    bus.req1_valid = d_v1;  bus.req1_cond = d_c1;  bus.req1_a = d_a1;
    bus.req1_b = d_b1;      bus.req1_target = d_t1;
    bus.resp_ready = d_rr;  bus.stat_clr = d_clr;
  endtask

  // One clock cycle: drive at negedge, compare to the model, advance the model.
  task automatic step();
    bit g0, g1, ev, hs;
    @(negedge clk);
    apply();
    #1;
    g0 = 1'b0;
    g1 = 1'b0;
    if (!m_busy) begin
      if (d_v0 && d_v1) begin g0 = m_last; g1 = !m_last; end
      else begin g0 = d_v0; g1 = d_v1; end
    end
    chk("req0_ready", bus.req0_ready, g0);
    chk("req1_ready", bus.req1_ready, g1);
    ev = m_busy && (m_age >= 2);
    chk("resp_valid", bus.resp_valid, ev);
    if (ev) begin
      chk("resp_taken", bus.resp_taken, m_exp.taken);
      chk("resp_illegal", bus.resp_illegal, m_exp.illegal);
      chk("resp_target", bus.resp_target, m_exp.target);
      chk("resp_id", bus.resp_id, m_exp.id);
    end
    if (m_busy) begin
      chk("cond_op", bus.cond_op, {24'd0, m_exp.cond});
      chk("cond_a", bus.cond_a, m_exp.a);
      chk("cond_b", bus.cond_b, m_exp.b);
    end
    chk("total_count", bus.total_count, m_tot);
    chk("taken_count", bus.taken_count, m_tak);
    hs = ev && d_rr;
    if (d_clr) begin
      m_tot = 0;
      m_tak = 0;
    end else if (hs) begin
      if (m_tot < CMAX) m_tot++;
      if (m_exp.taken && m_tak < CMAX) m_tak++;
    end
    if (hs) m_busy = 1'b0;
    else if (m_busy) m_age++;
    if (g0 || g1) begin
      m_busy         = 1'b1;
      m_age          = 1;
      m_last         = g1;
      m_exp.id       = g1;
      m_exp.cond     = g1 ? d_c1 : d_c0;
      m_exp.a        = g1 ? d_a1 : d_a0;
      m_exp.b        = g1 ? d_b1 : d_b0;
      m_exp.target   = g1 ? d_t1 : d_t0;
      m_exp.illegal  = m_exp.cond > 8'd9;
      m_exp.taken    = !m_exp.illegal && eval_cond({24'd0, m_exp.cond}, m_exp.a, m_exp.b);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    d_v0 = 0; d_v1 = 0; d_rr = 0; d_clr = 0;
    apply();
    rst = 1'b1;
    #1;
    chk("rst_resp_valid", bus.resp_valid, 0);
    chk("rst_resp_taken", bus.resp_taken, 0);
    chk("rst_resp_illegal", bus.resp_illegal, 0);
    chk("rst_resp_id", bus.resp_id, 0);
    chk("rst_resp_target", bus.resp_target, 0);
    chk("rst_cond_op", bus.cond_op, 0);
    chk("rst_cond_a", bus.cond_a, 0);
    chk("rst_cond_b", bus.cond_b, 0);
    chk("rst_req0_ready", bus.req0_ready, 0);
    chk("rst_req1_ready", bus.req1_ready, 0);
    chk("rst_total", bus.total_count, 0);
    chk("rst_taken", bus.taken_count, 0);
    m_busy = 1'b0; m_last = 1'b1; m_age = 0; m_tot = 0; m_tak = 0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Issue one branch on req0, wait for its response, complete the handshake.
  task automatic run_one(input logic [7:0] c, input logic [31:0] a, input logic [31:0] b, input logic [15:0] t);
    int n;
    d_v0 = 1; d_v1 = 0; d_c0 = c; d_a0 = a; d_b0 = b; d_t0 = t; d_rr = 1;
    step();
    d_v0 = 0;
    n = 0;
    do begin step(); n++; end while (!bus.resp_valid && n < 8);
    chk("run_one_resp", bus.resp_valid, 1);
    step();
  endtask

  typedef struct {
    logic [7:0]  cond;
    logic [31:0] a;
    logic [31:0] b;
    logic [15:0] tgt;
    bit          taken;
    bit          illegal;
  } vec_t;
  vec_t tbl[14];

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, exp_tak, n, tot0;
    int gq[$];
    int rq[$];
    logic [15:0] s_tgt;
    logic [31:0] s_a;
    bit s_tk, s_il, s_id;

    tbl[0]  = '{8'd0,  32'd5,        32'd5,        16'h1234, 1'b1, 1'b0};
    tbl[1]  = '{8'd2,  32'hFFFFFFFF, 32'd1,        16'h2000, 1'b0, 1'b0};
    tbl[2]  = '{8'd6,  32'hFFFFFFFF, 32'd1,        16'h2002, 1'b1, 1'b0};
    tbl[3]  = '{8'd9,  32'd7,        32'd7,        16'h2004, 1'b1, 1'b0};
    tbl[4]  = '{8'h0A, 32'd9,        32'd9,        16'h2006, 1'b0, 1'b1};
    tbl[5]  = '{8'd1,  32'd3,        32'd4,        16'h2008, 1'b1, 1'b0};
    tbl[6]  = '{8'd4,  32'd5,        32'd3,        16'h200A, 1'b1, 1'b0};
    tbl[7]  = '{8'd7,  32'hFFFFFFFF, 32'd0,        16'h200C, 1'b1, 1'b0};
    tbl[8]  = '{8'd8,  32'd0,        32'hFFFFFFFF, 16'h200E, 1'b1, 1'b0};
    tbl[9]  = '{8'd3,  32'd7,        32'd7,        16'h2010, 1'b1, 1'b0};
    tbl[10] = '{8'd5,  32'd1,        32'd2,        16'h2012, 1'b0, 1'b0};
    tbl[11] = '{8'd6,  32'd5,        32'hFFFFFFFD, 16'h2014, 1'b0, 1'b0};
    tbl[12] = '{8'hFF, 32'd1,        32'd2,        16'h2016, 1'b0, 1'b1};
    tbl[13] = '{8'd8,  32'h80000000, 32'd1,        16'hFFFE, 1'b0, 1'b0};

    rst = 1'b1;
    d_v0 = 0; d_v1 = 0; d_rr = 0; d_clr = 0;
    d_c0 = 0; d_c1 = 0; d_a0 = 0; d_b0 = 0; d_a1 = 0; d_b1 = 0; d_t0 = 0; d_t1 = 0;
    apply();
    do_reset();

    // Directed single branches with hand-derived decisions.
    exp_tak = 0;
    for (int i = 0; i < 14; i++) begin
      d_v0 = 1; d_c0 = tbl[i].cond; d_a0 = tbl[i].a; d_b0 = tbl[i].b; d_t0 = tbl[i].tgt; d_rr = 1;
      step();
      chk("tbl_ready0", bus.req0_ready, 1);
      d_v0 = 0;
      lat = 0;
      do begin step(); lat++; end while (!bus.resp_valid && lat < 8);
      chk("tbl_latency", lat, 2);
      chk("tbl_taken", bus.resp_taken, tbl[i].taken);
      chk("tbl_illegal", bus.resp_illegal, tbl[i].illegal);
      chk("tbl_target", bus.resp_target, tbl[i].tgt);
      chk("tbl_id", bus.resp_id, 0);
      if (tbl[i].taken) exp_tak++;
      step();
      chk("tbl_total", bus.total_count, i + 1);
      chk("tbl_taken_cnt", bus.taken_count, exp_tak);
    end

    // Tie arbitration from reset: grants alternate starting with req0.
    do_reset();
    d_v0 = 1; d_v1 = 1; d_c0 = 0; d_c1 = 1;
    d_a0 = 1; d_b0 = 1; d_a1 = 1; d_b1 = 2; d_t0 = 16'h0A00; d_t1 = 16'h0B00; d_rr = 1;
    n = 0;
    while (rq.size() < 4 && n < 40) begin
      step();
      if (bus.req0_ready) gq.push_back(0);
      if (bus.req1_ready) gq.push_back(1);
      if (bus.resp_valid) rq.push_back(int'(bus.resp_id));
      n++;
    end
    chk("tie_resp_count", rq.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk("tie_grant", (i < gq.size()) ? gq[i] : 99, i % 2);
      chk("tie_resp_id", (i < rq.size()) ? rq[i] : 99, i % 2);
    end
    d_v0 = 0; d_v1 = 0;
    for (int i = 0; i < 4; i++) step();

    // Backpressure: response and operands frozen, no new grants.
    d_v0 = 1; d_c0 = 8'd4; d_a0 = 32'hAB; d_b0 = 32'h0C; d_t0 = 16'h5555; d_rr = 0;
    step();
    d_c0 = 8'd0; d_a0 = 32'h77; d_v1 = 1;
    n = 0;
    do begin step(); n++; end while (!bus.resp_valid && n < 8);
    s_tk = bus.resp_taken; s_il = bus.resp_illegal; s_id = bus.resp_id;
    s_tgt = bus.resp_target; s_a = bus.cond_a;
    chk("bp_valid", bus.resp_valid, 1);
    chk("bp_taken", s_tk, 1);
    chk("bp_a", s_a, 32'hAB);
    tot0 = m_tot;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_hold_valid", bus.resp_valid, 1);
      chk("bp_hold_taken", bus.resp_taken, s_tk);
      chk("bp_hold_illegal", bus.resp_illegal, s_il);
      chk("bp_hold_id", bus.resp_id, s_id);
      chk("bp_hold_target", bus.resp_target, s_tgt);
      chk("bp_hold_cond_a", bus.cond_a, s_a);
      chk("bp_ready0", bus.req0_ready, 0);
      chk("bp_ready1", bus.req1_ready, 0);
    end
    d_rr = 1; d_v0 = 0; d_v1 = 0;
    step();
    step();
    chk("bp_released", bus.resp_valid, 0);
    chk("bp_total_once", bus.total_count, tot0 + 1);
    step();
    chk("bp_total_stable", bus.total_count, tot0 + 1);

    // Saturation, clear coinciding with a handshake.
    do_reset();
    for (int i = 0; i < CMAX - 1; i++) run_one(8'd0, 32'd3, 32'd3, 16'h0100);
    chk("sat_pre_total", bus.total_count, CMAX - 1);
    chk("sat_pre_taken", bus.taken_count, CMAX - 1);
    for (int i = 0; i < 3; i++) run_one(8'd0, 32'd3, 32'd3, 16'h0100);
    chk("sat_total", bus.total_count, CMAX);
    chk("sat_taken", bus.taken_count, CMAX);
    d_v0 = 1; d_c0 = 8'd0; d_rr = 0;
    step();
    d_v0 = 0;
    n = 0;
    do begin step(); n++; end while (!bus.resp_valid && n < 8);
    d_rr = 1; d_clr = 1;
    step();
    d_clr = 0; d_rr = 0;
    step();
    chk("clr_total", bus.total_count, 0);
    chk("clr_taken", bus.taken_count, 0);

    // Reset while the branch sits in ISSUE: nothing comes out afterwards.
    d_v0 = 1; d_c0 = 8'd1; d_a0 = 32'h1357; d_b0 = 32'h2468; d_t0 = 16'h4321; d_rr = 1;
    step();
    d_v0 = 0;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step();
      chk("post_rst_no_resp", bus.resp_valid, 0);
    end

    // Randomized traffic against the model; the unit misbehaves on illegal codes.
    garbage = 1'b1;
    for (int i = 0; i < 600; i++) begin
      d_v0 = ($urandom_range(0, 99) < 50);
      d_v1 = ($urandom_range(0, 99) < 50);
      d_c0 = 8'($urandom_range(0, 11));
      d_c1 = 8'($urandom_range(0, 11));
      case ($urandom_range(0, 4))
        0: d_a0 = 32'd0;  1: d_a0 = 32'hFFFFFFFF;  2: d_a0 = 32'h80000000;
        3: d_a0 = 32'd5;  default: d_a0 = $urandom;
      endcase
      d_b0 = ($urandom_range(0, 2) == 0) ? d_a0 : (($urandom_range(0, 1) == 0) ? 32'd5 : $urandom);
      d_a1 = ($urandom_range(0, 1) == 0) ? 32'd1 : $urandom;
      d_b1 = ($urandom_range(0, 2) == 0) ? d_a1 : $urandom;
      d_t0 = 16'($urandom);
      d_t1 = 16'($urandom);
      d_rr = ($urandom_range(0, 99) < 70);
      d_clr = ($urandom_range(0, 99) < 3);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
